// File: rtl/rv_data_memory_mmio.sv
// rtl/rv_data_memory_mmio.sv - RV32I byte-addressable data memory with LED/switch/key/7-seg/timer IO window
// Optional key interrupt: define RV_DMEM_KEY_IRQ_EN.
module rv_data_memory_mmio #(
    parameter int XLEN        = 32,
    parameter int DEPTH_WORDS = 64,
    parameter int IO_BASE     = 1024,
    parameter int NUM_LED     = 10,
    parameter int NUM_SW      = 10,
    parameter int NUM_KEY     = 4,
    parameter int NUM_HEX     = 6,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [XLEN-1:0]      address,
    input  logic [XLEN-1:0]      write_data,
    input  logic                 write_enable,
    input  logic [1:0]           size,
    input  logic                 read_unsigned,
    output logic [XLEN-1:0]      read_data,
    output logic                 misaligned,
    input  logic [NUM_SW-1:0]    sw_in,
    input  logic [NUM_KEY-1:0]   key_in,
    output logic [NUM_LED-1:0]   led_out,
    output logic [7*NUM_HEX-1:0] hex_out,
    output logic                 irq
);
    localparam int AW      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int NB      = XLEN / 8;
    localparam int IO_SPAN = 'h54;

    logic [XLEN-1:0]      ram [DEPTH_WORDS];
    logic [NUM_LED-1:0]   led_q;
    logic [4*NUM_HEX-1:0] hex_value;
    logic                 hex_mode;
    logic [6:0]           raw_seg [NUM_HEX];
    logic [NUM_SW-1:0]    sw_sync [SYNC_STAGES];
    logic [NUM_KEY-1:0]   key_sync [SYNC_STAGES];
    logic [NUM_KEY-1:0]   key_prev;
    logic [NUM_KEY-1:0]   key_event;
    logic [XLEN-1:0]      timer;
`ifdef RV_DMEM_KEY_IRQ_EN
    logic [NUM_KEY-1:0]   key_mask;
    logic                 irq_q;
`endif

    logic [XLEN-1:0]    io_diff;
    logic               ram_hit, io_hit, raw_hit;
    logic [4:0]         io_word, raw_off;
    logic [AW-1:0]      ram_index;
    logic [NUM_KEY-1:0] key_level, key_press, key_clear;
    logic               store_ok, ram_we, io_we;

    assign io_diff   = address - XLEN'(IO_BASE);
    assign ram_hit   = address < XLEN'(4 * DEPTH_WORDS);
    assign io_hit    = (address >= XLEN'(IO_BASE)) && (io_diff < XLEN'(IO_SPAN));
    assign io_word   = io_diff[6:2];
    assign raw_off   = io_word - 5'd4;
    assign raw_hit   = (io_word >= 5'd4) && (raw_off < 5'(NUM_HEX));
    assign ram_index = address[AW+1:2];

    assign misaligned = ((size == 2'b01) && address[0]) || (size[1] && (address[1:0] != 2'b00));

    // Keys are active-low on the pins; everything internal uses 1 = pressed.
    assign key_level = ~key_sync[SYNC_STAGES-1];
    assign key_press = key_level & ~key_prev;

    assign store_ok  = write_enable && !misaligned;
    assign ram_we    = store_ok && ram_hit;
    assign io_we     = store_ok && io_hit && size[1];
    assign key_clear = (io_we && io_word == 5'h12) ? write_data[NUM_KEY-1:0] : '0;

    // Read path: word select, then lane extract and extension.
    logic [XLEN-1:0] io_rdata, rd_word, rd_shift;

    always_comb begin
        io_rdata = '0;
        case (io_word)
            5'h00: io_rdata[NUM_LED-1:0]   = led_q;
            5'h01: io_rdata[4*NUM_HEX-1:0] = hex_value;
            5'h02: io_rdata[0]             = hex_mode;
            5'h10: io_rdata[NUM_SW-1:0]    = sw_sync[SYNC_STAGES-1];
            5'h11: io_rdata[NUM_KEY-1:0]   = key_level;
            5'h12: io_rdata[NUM_KEY-1:0]   = key_event;
            5'h13: io_rdata                = timer;
`ifdef RV_DMEM_KEY_IRQ_EN
            5'h14: io_rdata[NUM_KEY-1:0]   = key_mask;
`endif
            default: if (raw_hit) io_rdata[6:0] = raw_seg[raw_off[2:0]];
        endcase
    end

    always_comb begin
        rd_word   = ram_hit ? ram[ram_index] : (io_hit ? io_rdata : '0);
        rd_shift  = rd_word >> {address[1:0], 3'b000};
        read_data = '0;
        if (!misaligned) begin
            case (size)
                2'b00: read_data = read_unsigned ? {{(XLEN-8){1'b0}}, rd_shift[7:0]}
                                                 : {{(XLEN-8){rd_shift[7]}}, rd_shift[7:0]};
                2'b01: read_data = read_unsigned ? {{(XLEN-16){1'b0}}, rd_shift[15:0]}
                                                 : {{(XLEN-16){rd_shift[15]}}, rd_shift[15:0]};
                default: read_data = rd_word;
            endcase
        end
    end

    // Byte-lane merge for RAM stores.
    logic [NB-1:0]   lane_mask;
    logic [XLEN-1:0] lane_data;

    always_comb begin
        case (size)
            2'b00: begin
                lane_mask = NB'(1) << address[1:0];
                lane_data = {NB{write_data[7:0]}};
            end
            2'b01: begin
                lane_mask = NB'(3) << {address[1], 1'b0};
                lane_data = {(NB/2){write_data[15:0]}};
            end
            default: begin
                lane_mask = '1;
                lane_data = write_data;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH_WORDS; i++) ram[i] <= '0;
            for (int i = 0; i < NUM_HEX; i++) raw_seg[i] <= 7'h7F;
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sw_sync[s]  <= '0;
                key_sync[s] <= '1;
            end
            led_q     <= '0;
            hex_value <= '0;
            hex_mode  <= 1'b0;
            key_prev  <= '0;
            key_event <= '0;
            timer     <= '0;
`ifdef RV_DMEM_KEY_IRQ_EN
            key_mask  <= '0;
            irq_q     <= 1'b0;
`endif
        end else begin
            sw_sync[0]  <= sw_in;
            key_sync[0] <= key_in;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sw_sync[s]  <= sw_sync[s-1];
                key_sync[s] <= key_sync[s-1];
            end
            key_prev <= key_level;
            // A new press wins over a simultaneous write-1-to-clear.
            key_event <= (key_event & ~key_clear) | key_press;

            if (ram_we) begin
                for (int b = 0; b < NB; b++)
                    if (lane_mask[b]) ram[ram_index][8*b +: 8] <= lane_data[8*b +: 8];
            end

            if (io_we && io_word == 5'h13) timer <= write_data;
            else                           timer <= timer + XLEN'(1);

            if (io_we) begin
                case (io_word)
                    5'h00: led_q     <= write_data[NUM_LED-1:0];
                    5'h01: hex_value <= write_data[4*NUM_HEX-1:0];
                    5'h02: hex_mode  <= write_data[0];
`ifdef RV_DMEM_KEY_IRQ_EN
                    5'h14: key_mask  <= write_data[NUM_KEY-1:0];
`endif
                    default: if (raw_hit) raw_seg[raw_off[2:0]] <= write_data[6:0];
                endcase
            end
`ifdef RV_DMEM_KEY_IRQ_EN
            irq_q <= |(key_event & key_mask);
`endif
        end
    end

`ifdef RV_DMEM_KEY_IRQ_EN
    assign irq = irq_q;
`else
    assign irq = 1'b0;
`endif

    assign led_out = led_q;

    function automatic logic [6:0] seg7_n(input logic [3:0] v);
        case (v)
            4'h0: seg7_n = 7'h40;  4'h1: seg7_n = 7'h79;
            4'h2: seg7_n = 7'h24;  4'h3: seg7_n = 7'h30;
            4'h4: seg7_n = 7'h19;  4'h5: seg7_n = 7'h12;
            4'h6: seg7_n = 7'h02;  4'h7: seg7_n = 7'h78;
            4'h8: seg7_n = 7'h00;  4'h9: seg7_n = 7'h10;
            4'hA: seg7_n = 7'h08;  4'hB: seg7_n = 7'h03;
            4'hC: seg7_n = 7'h46;  4'hD: seg7_n = 7'h21;
            4'hE: seg7_n = 7'h06;  default: seg7_n = 7'h0E;
        endcase
    endfunction

    always_comb begin
        hex_out = '1;
        for (int i = 0; i < NUM_HEX; i++)
            hex_out[7*i +: 7] = hex_mode ? seg7_n(hex_value[4*i +: 4]) : raw_seg[i];
    end
endmodule

// File: tb/tb_rv_data_memory_mmio.sv
// tb/tb_rv_data_memory_mmio.sv - randomized self-checking bench for rv_data_memory_mmio
module tb_rv_data_memory_mmio;
    localparam int IO = 1024;
    localparam int S  = 2;

    logic        clock = 1'b0;
    logic        reset, write_enable, read_unsigned;
    logic [31:0] address, write_data;
    logic [1:0]  size;
    logic [9:0]  sw_in;
    logic [3:0]  key_in;
    logic [31:0] read_data;
    logic        misaligned;
    logic [9:0]  led_out;
    logic [41:0] hex_out;
    logic        irq;

    int checks = 0;
    int errors = 0;
    logic [7:0] mem_model [256];

    rv_data_memory_mmio dut (
        .clock(clock), .reset(reset), .address(address), .write_data(write_data),
        .write_enable(write_enable), .size(size), .read_unsigned(read_unsigned),
        .read_data(read_data), .misaligned(misaligned), .sw_in(sw_in), .key_in(key_in),
        .led_out(led_out), .hex_out(hex_out), .irq(irq)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic logic is_mis(input logic [31:0] a, input logic [1:0] s);
        return (s == 2'd1 && a[0]) || (s >= 2'd2 && a[1:0] != 2'd0);
    endfunction

    function automatic int nbytes(input logic [1:0] s);
        return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] s, input logic u);
        logic [31:0] v;
        int n;
        if (is_mis(a, s) || a >= 256) return 32'h0;
        n = nbytes(s);
        v = 0;
        for (int k = 0; k < n; k++) v = v | (32'(mem_model[a + k]) << (8 * k));
        if (!u && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
        return v;
    endfunction

    function automatic logic [6:0] seg_on(input logic [3:0] v);
        logic [6:0] t [16];
        t = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        return t[v];
    endfunction

    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
        @(negedge clock);
        address = a; write_data = d; size = s; write_enable = 1'b1;
        @(negedge clock);
        write_enable = 1'b0;
        if (!is_mis(a, s) && a < 256)
            for (int k = 0; k < nbytes(s); k++) mem_model[a + k] = d[8*k +: 8];
    endtask

    task automatic load(input logic [31:0] a, input logic [1:0] s, input logic u, output logic [31:0] r);
        address = a; size = s; read_unsigned = u;
        #1;
        r = read_data;
    endtask

    task automatic test_reset;
        logic [31:0] r;
        reset = 1'b1; write_enable = 1'b0; address = 0; write_data = 0; size = 2;
        read_unsigned = 0; sw_in = 0; key_in = '1;
        for (int i = 0; i < 256; i++) mem_model[i] = 8'h00;
        repeat (2) @(negedge clock);
        checks++; if (led_out !== 10'h0) begin errors++; $display("FAIL reset_led got %h want 0", led_out); end
        checks++; if (hex_out !== {42{1'b1}}) begin errors++; $display("FAIL reset_hex got %h want all ones", hex_out); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %b want 0", irq); end
        reset = 1'b0;
        load(IO + 'h4C, 2, 0, r);
        checks++; if (r !== 32'h0) begin errors++; $display("FAIL reset_timer got %h want 0", r); end
        load(IO + 'h10, 2, 0, r);
        checks++; if (r !== 32'h7F) begin errors++; $display("FAIL reset_rawseg got %h want 7f", r); end
    endtask

    task automatic test_ram_directed;
        logic [31:0] r;
        store(8, 32'h8899AABB, 2);
        load(9, 0, 0, r);
        checks++; if (r !== 32'hFFFFFFAA) begin errors++; $display("FAIL lb9 got %h want ffffffaa", r); end
        load(9, 0, 1, r);
        checks++; if (r !== 32'h000000AA) begin errors++; $display("FAIL lbu9 got %h want 000000aa", r); end
        load(10, 1, 0, r);
        checks++; if (r !== 32'hFFFF8899) begin errors++; $display("FAIL lh10 got %h want ffff8899", r); end
        store(0, 32'h11223344, 2);
        store(3, 32'h5A, 0);
        load(0, 2, 0, r);
        checks++; if (r !== 32'h5A223344) begin errors++; $display("FAIL sb3 got %h want 5a223344", r); end
        address = 1; size = 1; #1;
        checks++; if (misaligned !== 1'b1) begin errors++; $display("FAIL mis_sh1 got %b want 1", misaligned); end
        store(1, 32'hBEEF, 1);
        load(0, 2, 0, r);
        checks++; if (r !== 32'h5A223344) begin errors++; $display("FAIL mis_store got %h want 5a223344", r); end
        load(1, 2, 0, r);
        checks++; if (r !== 32'h0) begin errors++; $display("FAIL mis_load got %h want 0", r); end
    endtask

    task automatic test_ram_random;
        logic [31:0] a, d, r, e;
        logic [1:0] s;
        logic u;
        for (int i = 0; i < 300; i++) begin
            a = $urandom_range(0, 299);
            s = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) begin
                d = $urandom;
                store(a, d, s);
            end else begin
                u = 1'($urandom_range(0, 1));
                load(a, s, u, r);
                e = model_load(a, s, u);
                checks++;
                if (r !== e) begin errors++; $display("FAIL rand_load a=%0d s=%0d u=%0d got %h want %h", a, s, u, r, e); end
                checks++;
                if (misaligned !== is_mis(a, s)) begin errors++; $display("FAIL rand_mis a=%0d s=%0d got %b want %b", a, s, misaligned, is_mis(a, s)); end
            end
        end
    endtask

    task automatic test_io;
        logic [31:0] r, e;
        logic [9:0] sv;
        store(IO, 32'hFFFF_FFFF, 2);
        checks++; if (led_out !== 10'h3FF) begin errors++; $display("FAIL led_word got %h want 3ff", led_out); end
        load(IO + 1, 0, 1, r);
        checks++; if (r !== 32'h3) begin errors++; $display("FAIL led_lbu got %h want 3", r); end
        store(IO, 32'h0, 0);
        checks++; if (led_out !== 10'h3FF) begin errors++; $display("FAIL led_subword got %h want 3ff", led_out); end
        store(IO + 'h0C, 32'h1234, 2);
        load(IO + 'h0C, 2, 0, r);
        checks++; if (r !== 32'h0) begin errors++; $display("FAIL unused_reg got %h want 0", r); end
        store(IO + 4, 32'hFF123456, 2);
        store(IO + 8, 32'h1, 2);
        load(IO + 4, 2, 0, r);
        checks++; if (r !== 32'h00123456) begin errors++; $display("FAIL hexval got %h want 00123456", r); end
        for (int i = 0; i < 6; i++) begin
            e = 32'(~seg_on(4'(6 - i)));
            checks++;
            if (hex_out[7*i +: 7] !== e[6:0]) begin errors++; $display("FAIL hex_digit%0d got %h want %h", i, hex_out[7*i +: 7], e[6:0]); end
        end
        store(IO + 8, 32'h0, 2);
        checks++; if (hex_out !== {42{1'b1}}) begin errors++; $display("FAIL hex_raw_blank got %h want all ones", hex_out); end
        store(IO + 'h1C, 32'h1AB, 2);
        checks++; if (hex_out[27:21] !== 7'h2B) begin errors++; $display("FAIL raw3_out got %h want 2b", hex_out[27:21]); end
        load(IO + 'h1C, 2, 0, r);
        checks++; if (r !== 32'h2B) begin errors++; $display("FAIL raw3_read got %h want 2b", r); end
        store(IO + 'h1C, 32'h7F, 2);
        sv = 10'($urandom) | 10'h1;
        @(negedge clock); sw_in = sv;
        for (int k = 0; k < S; k++) begin
            load(IO + 'h40, 2, 0, r);
            checks++; if (r !== 32'h0) begin errors++; $display("FAIL sw_sync_early k=%0d got %h want 0", k, r); end
            @(negedge clock);
        end
        load(IO + 'h40, 2, 0, r);
        checks++; if (r !== 32'(sv)) begin errors++; $display("FAIL sw_sync got %h want %h", r, sv); end
    endtask

    task automatic test_keys;
        logic [31:0] r;
        @(negedge clock); key_in[2] = 1'b0;
        for (int k = 0; k < S; k++) begin
            @(negedge clock);
            load(IO + 'h48, 2, 0, r);
            checks++; if (r !== 32'h0) begin errors++; $display("FAIL key_event_early k=%0d got %h want 0", k, r); end
        end
        load(IO + 'h44, 2, 0, r);
        checks++; if (r !== 32'h4) begin errors++; $display("FAIL key_level got %h want 4", r); end
        @(negedge clock);
        load(IO + 'h48, 2, 0, r);
        checks++; if (r !== 32'h4) begin errors++; $display("FAIL key_event_set got %h want 4", r); end
        repeat (2) @(negedge clock);
        key_in[2] = 1'b1;
        repeat (S + 3) @(negedge clock);
        load(IO + 'h48, 2, 0, r);
        checks++; if (r !== 32'h4) begin errors++; $display("FAIL key_event_sticky got %h want 4", r); end
        store(IO + 'h48, 32'h4, 2);
        load(IO + 'h48, 2, 0, r);
        checks++; if (r !== 32'h0) begin errors++; $display("FAIL key_w1c got %h want 0", r); end
        @(negedge clock); key_in[2] = 1'b0;
        repeat (S) @(negedge clock);
        address = IO + 'h48; write_data = 32'h4; size = 2; write_enable = 1'b1;
        @(negedge clock);
        write_enable = 1'b0;
        load(IO + 'h48, 2, 0, r);
        checks++; if (r !== 32'h4) begin errors++; $display("FAIL key_set_wins got %h want 4", r); end
        key_in[2] = 1'b1;
        store(IO + 'h48, 32'h4, 2);
        load(IO + 'h48, 2, 0, r);
        checks++; if (r !== 32'h0) begin errors++; $display("FAIL key_clear_later got %h want 0", r); end
        repeat (S + 2) @(negedge clock);
    endtask

    task automatic test_timer;
        logic [31:0] r;
        store(IO + 'h4C, 32'hFFFFFFFE, 2);
        load(IO + 'h4C, 2, 0, r);
        checks++; if (r !== 32'hFFFFFFFE) begin errors++; $display("FAIL timer_load got %h want fffffffe", r); end
        @(negedge clock);
        load(IO + 'h4C, 2, 0, r);
        checks++; if (r !== 32'hFFFFFFFF) begin errors++; $display("FAIL timer_inc got %h want ffffffff", r); end
        @(negedge clock);
        load(IO + 'h4C, 2, 0, r);
        checks++; if (r !== 32'h0) begin errors++; $display("FAIL timer_wrap got %h want 0", r); end
    endtask

    task automatic test_irq;
        logic [31:0] r;
`ifdef RV_DMEM_KEY_IRQ_EN
        store(IO + 'h50, 32'hFFFF_FFF1, 2);
        load(IO + 'h50, 2, 0, r);
        checks++; if (r !== 32'h1) begin errors++; $display("FAIL mask_read got %h want 1", r); end
        @(negedge clock); key_in[1] = 1'b0;
        repeat (S + 3) @(negedge clock);
        load(IO + 'h48, 2, 0, r);
        checks++; if (r !== 32'h2) begin errors++; $display("FAIL irq_key1_event got %h want 2", r); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_masked got %b want 0", irq); end
        key_in[1] = 1'b1;
        repeat (S + 2) @(negedge clock);
        key_in[0] = 1'b0;
        repeat (S + 1) @(negedge clock);
        load(IO + 'h48, 2, 0, r);
        checks++; if (r !== 32'h3) begin errors++; $display("FAIL irq_key0_event got %h want 3", r); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_early got %b want 0", irq); end
        @(negedge clock);
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_raise got %b want 1", irq); end
        key_in[0] = 1'b1;
        store(IO + 'h48, 32'h3, 2);
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_hold got %b want 1", irq); end
        @(negedge clock);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_clear got %b want 0", irq); end
`else
        store(IO + 'h50, 32'hF, 2);
        load(IO + 'h50, 2, 0, r);
        checks++; if (r !== 32'h0) begin errors++; $display("FAIL mask_disabled got %h want 0", r); end
        @(negedge clock); key_in[0] = 1'b0;
        repeat (S + 3) @(negedge clock);
        load(IO + 'h48, 2, 0, r);
        checks++; if (r !== 32'h1) begin errors++; $display("FAIL key0_event got %h want 1", r); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_tied got %b want 0", irq); end
        key_in[0] = 1'b1;
        store(IO + 'h48, 32'h1, 2);
`endif
        repeat (S + 2) @(negedge clock);
    endtask

    task automatic test_mid_reset;
        logic [31:0] r;
        store(IO, 32'h2AA, 2);
        store(IO + 4, 32'h888888, 2);
        store(IO + 8, 32'h1, 2);
        store(0, 32'hCAFEF00D, 2);
        checks++; if (led_out !== 10'h2AA) begin errors++; $display("FAIL pre_reset_led got %h want 2aa", led_out); end
        @(negedge clock);
        reset = 1'b1; address = 0; write_data = 32'hDEADBEEF; size = 2; write_enable = 1'b1;
        @(negedge clock);
        reset = 1'b0; write_enable = 1'b0;
        for (int i = 0; i < 256; i++) mem_model[i] = 8'h00;
        checks++; if (led_out !== 10'h0) begin errors++; $display("FAIL mid_reset_led got %h want 0", led_out); end
        checks++; if (hex_out !== {42{1'b1}}) begin errors++; $display("FAIL mid_reset_hex got %h want all ones", hex_out); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL mid_reset_irq got %b want 0", irq); end
        load(0, 2, 0, r);
        checks++; if (r !== 32'h0) begin errors++; $display("FAIL mid_reset_ram got %h want 0", r); end
        load(IO + 'h4C, 2, 0, r);
        checks++; if (r !== 32'h0) begin errors++; $display("FAIL mid_reset_timer got %h want 0", r); end
    endtask

    initial begin
        test_reset();
        test_ram_directed();
        test_ram_random();
        test_io();
        test_keys();
        test_timer();
        test_irq();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
